// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite pixel ROM between several renderers.
// Supports locked row bursts (capped at MAX_BURST) and returns tagged palette data two cycles after grant.
module sprite_rom_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int ADDR_W    = 8,
   parameter  int DATA_W    = 2,
   parameter  int MAX_BURST = 14,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                        vga_clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]          lock,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]           rom_address,
   input  logic [DATA_W-1:0]           rom_q,
   output logic                        rd_valid,
   output logic [ID_W-1:0]             rd_id,
   output logic [DATA_W-1:0]           rd_data
);

   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    owner_q, owner_d;
   logic               owner_vld_q, owner_vld_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic               s1_vld_q, s1_vld_d;
   logic [ID_W-1:0]    s1_id_q, s1_id_d;
   logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
   logic               rd_valid_q, rd_valid_d;
   logic [ID_W-1:0]    rd_id_q, rd_id_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;

   logic [NUM_REQ-1:0] owner_bit;
   logic [NUM_REQ-1:0] cand;
   logic               lock_cont;
   logic               cap_skip;
   logic               rr_found;
   logic [ID_W-1:0]    rr_win;
   logic               any_win;
   logic [ID_W-1:0]    win;
   logic               accept;

   always_comb begin
      owner_bit          = '0;
      owner_bit[owner_q] = 1'b1;
      lock_cont = owner_vld_q & req[owner_q] & lock[owner_q] &
                  (burst_cnt_q < CNT_W'(MAX_BURST));
      // An exhausted burst yields to anyone else waiting, regardless of rr_ptr.
      cap_skip  = owner_vld_q & (burst_cnt_q == CNT_W'(MAX_BURST)) &
                  (|(req & ~owner_bit));
      cand      = cap_skip ? (req & ~owner_bit) : req;
   end

   always_comb begin
      int idx;
      rr_found = 1'b0;
      rr_win   = '0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!rr_found && cand[idx]) begin
            rr_found = 1'b1;
            rr_win   = ID_W'(idx);
         end
      end
   end

   always_comb begin
      any_win = lock_cont | rr_found;
      win     = lock_cont ? owner_q : rr_win;
      accept  = any_win & reset_n;
      gnt     = '0;
      if (accept) gnt[win] = 1'b1;
   end

   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      owner_d       = owner_q;
      owner_vld_d   = 1'b0;
      burst_cnt_d   = '0;
      s1_vld_d      = 1'b0;
      s1_id_d       = s1_id_q;
      rom_address_d = rom_address_q;
      if (accept) begin
         rom_address_d = req_addr[win*ADDR_W +: ADDR_W];
         s1_vld_d      = 1'b1;
         s1_id_d       = win;
         rr_ptr_d      = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
         burst_cnt_d   = lock_cont ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
         owner_d       = win;
         owner_vld_d   = 1'b1;
      end
      rd_valid_d = s1_vld_q;
      rd_id_d    = s1_id_q;
      rd_data_d  = rom_q;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q      <= '0;
         owner_q       <= '0;
         owner_vld_q   <= 1'b0;
         burst_cnt_q   <= '0;
         s1_vld_q      <= 1'b0;
         s1_id_q       <= '0;
         rom_address_q <= '0;
         rd_valid_q    <= 1'b0;
         rd_id_q       <= '0;
         rd_data_q     <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         owner_q       <= owner_d;
         owner_vld_q   <= owner_vld_d;
         burst_cnt_q   <= burst_cnt_d;
         s1_vld_q      <= s1_vld_d;
         s1_id_q       <= s1_id_d;
         rom_address_q <= rom_address_d;
         rd_valid_q    <= rd_valid_d;
         rd_id_q       <= rd_id_d;
         rd_data_q     <= rd_data_d;
      end
   end

   assign rom_address = rom_address_q;
   assign rd_valid    = rd_valid_q;
   assign rd_id       = rd_id_q;
   assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: behavioural arbitration model predicts
// grants and returned palette data; a monitor checks tagged returns independently.
module tb_sprite_rom_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 2;
   localparam int MB = 14;

   logic            vga_clk;
   logic            reset_n;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    lock;
   logic [N-1:0]    gnt;
   logic [AW-1:0]   rom_address;
   logic [DW-1:0]   rom_q;
   logic            rd_valid;
   logic [1:0]      rd_id;
   logic [DW-1:0]   rd_data;

   sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
      .lock(lock), .gnt(gnt), .rom_address(rom_address), .rom_q(rom_q),
      .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data));

   int checks = 0;
   int errors = 0;

   typedef struct { int id; int data; } exp_t;
   exp_t sb[$];
   int   win_log[$];

   logic [DW-1:0] rom_mem [256];

   // reference state
   int m_rr, m_owner, m_burst, m_exp_addr;
   bit m_owner_vld;

   initial begin
      vga_clk = 0;
      forever #5 vga_clk = ~vga_clk;
   end

   always @(negedge vga_clk) rom_q <= rom_mem[rom_address];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge vga_clk) begin
      #1;
      if (reset_n && rd_valid) begin
         if (sb.size() == 0) begin
            chk("rd_valid_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_id", int'(rd_id), e.id);
            chk("rd_data", int'(rd_data), e.data);
         end
      end
   end

   function automatic void model_reset();
      m_rr = 0; m_owner = 0; m_burst = 0; m_owner_vld = 0; m_exp_addr = 0;
   endfunction

   // Returns winner index or -1; cont reports a locked continuation.
   function automatic int model_pick(input logic [N-1:0] r, input logic [N-1:0] l, output bit cont);
      bit others;
      cont = 0;
      if (m_owner_vld && r[m_owner] && l[m_owner] && m_burst < MB) begin
         cont = 1;
         return m_owner;
      end
      others = 0;
      for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others = 1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (r[i] && !(m_owner_vld && m_burst == MB && others && i == m_owner)) return i;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] g);
      if ($countones(g) != 1) return -1;
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*AW-1:0] a);
      int w;
      bit cont;
      exp_t e;
      @(negedge vga_clk);
      #1;
      req = r; lock = l; req_addr = a;
      #2;
      w = model_pick(r, l, cont);
      chk("gnt", int'(gnt), (w >= 0) ? (1 << w) : 0);
      win_log.push_back(onehot_idx(gnt));
      if (w >= 0) begin
         m_exp_addr = int'(a[w*AW +: AW]);
         e.id   = w;
         e.data = int'(rom_mem[m_exp_addr]);
         sb.push_back(e);
      end
      @(posedge vga_clk);
      if (w >= 0) begin
         m_burst = cont ? m_burst + 1 : 1;
         m_owner = w; m_owner_vld = 1; m_rr = (w + 1) % N;
      end else begin
         m_owner_vld = 0; m_burst = 0;
      end
      #1;
      chk("rom_address", int'(rom_address), m_exp_addr);
   endtask

   task automatic do_reset();
      @(negedge vga_clk);
      #1;
      reset_n = 0; req = '0; lock = '0;
      #1;
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_rd_valid_async", int'(rd_valid), 0);
      sb.delete();
      model_reset();
      @(posedge vga_clk);
      #1;
      chk("rst_rom_address", int'(rom_address), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_id", int'(rd_id), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      @(negedge vga_clk);
      #1;
      reset_n = 1;
   endtask

   function automatic logic [N*AW-1:0] rand_addr();
      logic [N*AW-1:0] v;
      for (int i = 0; i < N; i++) v[i*AW +: AW] = AW'($urandom_range(0, 255));
      return v;
   endfunction

   initial begin
      logic [N*AW-1:0] a;
      logic [N-1:0]    lk;
      reset_n = 0; req = '0; lock = '0; req_addr = '0;
      for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom_range(0, 3));
      rom_mem[5] = 2'd3;
      model_reset();
      do_reset();

      // single request for address 5 from requester 0
      a = '0; a[AW-1:0] = 8'd5;
      step(4'b0001, 4'b0000, a);
      chk("t1_gnt0", win_log[$], 0);
      chk("t1_rom_addr5", int'(rom_address), 5);
      step(4'b0000, 4'b0000, a);
      @(negedge vga_clk);
      chk("t1_rd_valid", int'(rd_valid), 1);
      chk("t1_rd_data", int'(rd_data), 3);

      // plain round robin
      do_reset();
      win_log.delete();
      for (int c = 0; c < 12; c++) step(4'b1111, 4'b0000, rand_addr());
      for (int c = 0; c < 12; c++) chk("t2_rr_order", win_log[c], c % 4);

      // locked bursts capped at MB
      do_reset();
      win_log.delete();
      for (int c = 0; c < 32; c++) step(4'b0011, 4'b0001, rand_addr());
      for (int c = 0; c < 29; c++) chk("t3_burst_pattern", win_log[c], (c == 14) ? 1 : 0);

      // lone locked requester never stalls
      do_reset();
      win_log.delete();
      for (int c = 0; c < 30; c++) step(4'b0001, 4'b0001, rand_addr());
      for (int c = 0; c < 30; c++) chk("t4_alone", win_log[c], 0);

      // rr_ptr wrap
      do_reset();
      win_log.delete();
      step(4'b0100, 4'b0000, rand_addr());
      step(4'b1000, 4'b0000, rand_addr());
      step(4'b1001, 4'b0000, rand_addr());
      step(4'b1001, 4'b0000, rand_addr());
      chk("t5_wrap_first", win_log[2], 0);
      chk("t5_wrap_second", win_log[3], 3);

      // reset right after an accept discards the in-flight read
      do_reset();
      step(4'b0100, 4'b0000, rand_addr());
      do_reset();
      step(4'b0000, 4'b0000, rand_addr());
      chk("t6_no_stale_1", int'(rd_valid), 0);
      step(4'b0000, 4'b0000, rand_addr());
      chk("t6_no_stale_2", int'(rd_valid), 0);
      win_log.delete();
      step(4'b1111, 4'b0000, rand_addr());
      chk("t6_restart_rr0", win_log[0], 0);

      // randomized traffic with sticky locks and occasional reset
      lk = '0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) lk = N'($urandom_range(0, 15));
         if ($urandom_range(0, 149) == 0) do_reset();
         step(N'($urandom_range(0, 15)), lk, rand_addr());
      end

      for (int c = 0; c < 4; c++) step(4'b0000, 4'b0000, rand_addr());
      chk("drain_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
